// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings, states and lane helpers for the load/store unit
package lsu_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, RMW_WR, WR, DONE} lsu_state_e;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD = 2'b11;
  localparam logic [31:0] BYTE_LANE = 32'h0000_00ff;
  localparam logic [31:0] HALF_LANE = 32'h0000_ffff;
  // Big-endian lanes: offset 0 is the most significant byte, so the shift to
  // bring a lane down to bit 0 is (3-off)*8 for bytes and (2-off)*8 for halves.
  function automatic logic [4:0] lane_shift(input logic [1:0] sz, input logic [1:0] off);
    return sz == SZ_BYTE ? {~off, 3'b000} : sz == SZ_HALF ? {~off[1], 4'b0000} : 5'd0;
  endfunction
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    return (sz == SZ_HALF && off[0]) || (sz == SZ_WORD && off != 2'b00) || sz == SZ_BAD;
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: sub-word load extraction/extension and store lane merge
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        signed_load,
  input  logic [31:0] rdata,
  input  logic [31:0] merge_buf,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merge_val
);
  logic [4:0] sh;
  logic [31:0] lane, mask, rep;
  assign sh = lane_shift(size, offset);
  assign lane = rdata >> sh;
  assign mask = (size == SZ_BYTE ? BYTE_LANE : size == SZ_HALF ? HALF_LANE : 32'hffff_ffff) << sh;
  assign rep = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
  assign load_val = size == SZ_BYTE ? {{24{signed_load & lane[7]}}, lane[7:0]}
                  : size == SZ_HALF ? {{16{signed_load & lane[15]}}, lane[15:0]} : lane;
  assign merge_val = (merge_buf & ~mask) | (rep & mask);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multicycle byte/half/word sequencer onto a word-addressed memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 101
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        isStore,
  input  logic [1:0]  size,
  input  logic        signedLoad,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic [31:0] loadData,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] memAddress,
  input  logic [31:0] memDataIn,
  output logic [31:0] memDataOut,
  output logic        memRead,
  output logic        memWrite
);
  lsu_state_e state, nxt;
  logic [1:0] sz, off;
  logic sgn, flt, bad, accept;
  logic [31:0] sdata, mbuf, ld_val, merge_val;
  assign accept = state == IDLE && req;
  assign bad = misaligned(size, addr[1:0]) || {2'b00, addr[31:2]} >= 32'(MEM_WORDS);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign fault = done && flt;
  assign memRead = state == LOAD || state == RMW_RD;
  assign memWrite = (state == WR || state == RMW_WR) && !reset;
  assign memDataOut = (state == WR || state == RMW_WR) ? merge_val : '0;
  lsu_lane_align u_align (
    .size(sz),
    .offset(off),
    .signed_load(sgn),
    .rdata(memDataIn),
    .merge_buf(mbuf),
    .wdata(sdata),
    .load_val(ld_val),
    .merge_val(merge_val)
  );
  // state register
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : nxt;
  end
  // dispatch on acceptance, then walk the fixed access sequence to DONE
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = !req ? IDLE : bad ? DONE : !isStore ? LOAD : size == SZ_WORD ? WR : RMW_RD;
      LOAD, WR, RMW_WR: nxt = DONE;
      RMW_RD: nxt = RMW_WR;
      default: nxt = IDLE;
    endcase
  end
  // request latch, merge buffer capture and load result register
  always_ff @(posedge clk) begin
    if (reset) begin
      {sz, off, sgn, flt, sdata, mbuf, memAddress, loadData} <= '0;
    end else begin
      if (accept) begin
        sz <= size;
        off <= addr[1:0];
        sgn <= signedLoad;
        flt <= bad;
        sdata <= storeData;
        memAddress <= {2'b00, addr[31:2]};
      end
      if (state == LOAD) loadData <= ld_val;
      if (state == RMW_RD) mbuf <= memDataIn;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table, directed and random checks against a byte-level model
module tb_load_store_unit;
  logic clk = 0, reset = 1, req = 0, isStore = 0, signedLoad = 0;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, storeData = 0;
  logic [31:0] loadData, memAddress, memDataIn, memDataOut;
  logic busy, done, fault, memRead, memWrite;
  logic [31:0] mem [128] = '{default: '0};
  logic [31:0] ref_mem [128] = '{default: '0};
  logic [31:0] ref_ld = 0;
  logic tb_we = 0;
  logic [6:0] tb_idx = 0;
  logic [31:0] tb_wd = 0;
  int rd_cnt = 0, wr_cnt = 0, checks = 0, errors = 0;
  logic both_seen = 0;

  load_store_unit #(.MEM_WORDS(101)) dut (
    .clk(clk), .reset(reset), .req(req), .isStore(isStore), .size(size),
    .signedLoad(signedLoad), .addr(addr), .storeData(storeData), .loadData(loadData),
    .busy(busy), .done(done), .fault(fault), .memAddress(memAddress),
    .memDataIn(memDataIn), .memDataOut(memDataOut), .memRead(memRead), .memWrite(memWrite)
  );

  always #5 clk = ~clk;
  assign memDataIn = memRead ? mem[memAddress[6:0]] : '0;

  always @(posedge clk) begin
    if (tb_we) mem[tb_idx] <= tb_wd;
    if (memWrite) mem[memAddress[6:0]] <= memDataOut;
    if (memRead) rd_cnt <= rd_cnt + 1;
    if (memWrite) wr_cnt <= wr_cnt + 1;
    if (memRead && memWrite) both_seen <= 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    return w[8*(3-k) +: 8];
  endfunction

  function automatic logic model_fault(input logic [1:0] sz, input logic [31:0] a);
    return sz == 3 || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0) || a / 4 >= 101;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic s, input logic [31:0] a);
    int k = int'(a % 4);
    int v;
    if (sz == 2) return w;
    if (sz == 0) begin
      v = int'(byte_of(w, k));
      if (s && v >= 128) v -= 256;
    end else begin
      v = int'(byte_of(w, k)) * 256 + int'(byte_of(w, k + 1));
      if (s && v >= 32768) v -= 65536;
    end
    return 32'(v);
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [31:0] d, input logic [31:0] a);
    logic [7:0] b [4];
    int k = int'(a % 4);
    if (sz == 2) return d;
    for (int i = 0; i < 4; i++) b[i] = byte_of(w, i);
    if (sz == 0) b[k] = d[7:0];
    else begin
      b[k] = d[15:8];
      b[k+1] = d[7:0];
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  task automatic apply(input string nm, input logic st, input logic [1:0] sz, input logic s,
                       input logic [31:0] a, input logic [31:0] d, input logic ef,
                       input int el, input logic [31:0] eld, input logic [31:0] ew);
    int lat = 8, r0, w0;
    logic flt = 0;
    logic [6:0] idx = a[8:2];
    @(negedge clk);
    r0 = rd_cnt;
    w0 = wr_cnt;
    req = 1; isStore = st; size = sz; signedLoad = s; addr = a; storeData = d;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      req = 0;
      if (done) begin
        lat = i;
        flt = fault;
        break;
      end
    end
    chk({nm, ".lat"}, 32'(lat), 32'(el));
    chk({nm, ".fault"}, {31'b0, flt}, {31'b0, ef});
    chk({nm, ".loadData"}, loadData, eld);
    chk({nm, ".word"}, mem[idx], ew);
    chk({nm, ".reads"}, 32'(rd_cnt - r0), (ef || (st && sz == 2)) ? 0 : 1);
    chk({nm, ".writes"}, 32'(wr_cnt - w0), (ef || !st) ? 0 : 1);
    ref_ld = eld;
    if (st && !ef) ref_mem[idx] = ew;
  endtask

  typedef struct {
    logic st; logic [1:0] sz; logic sg; logic [31:0] a; logic [31:0] d;
    logic ef; int el; logic [31:0] eld; logic [31:0] ew;
  } vec_t;
  vec_t tbl [12];

  initial begin
    tbl[0]  = '{0, 2'd0, 1, 32'h50, 32'h0, 0, 2, 32'hFFFFFF80, 32'h80FF1234};
    tbl[1]  = '{0, 2'd0, 0, 32'h51, 32'h0, 0, 2, 32'h000000FF, 32'h80FF1234};
    tbl[2]  = '{0, 2'd1, 1, 32'h52, 32'h0, 0, 2, 32'h00001234, 32'h80FF1234};
    tbl[3]  = '{0, 2'd1, 1, 32'h51, 32'h0, 1, 1, 32'h00001234, 32'h80FF1234};
    tbl[4]  = '{1, 2'd0, 0, 32'h53, 32'hAB, 0, 3, 32'h00001234, 32'h80FF12AB};
    tbl[5]  = '{1, 2'd2, 0, 32'h54, 32'hDEADBEEF, 0, 2, 32'h00001234, 32'hDEADBEEF};
    tbl[6]  = '{1, 2'd2, 0, 32'h194, 32'h11111111, 1, 1, 32'h00001234, 32'h0};
    tbl[7]  = '{0, 2'd2, 0, 32'h50, 32'h0, 0, 2, 32'h80FF12AB, 32'h80FF12AB};
    tbl[8]  = '{0, 2'd3, 0, 32'h50, 32'h0, 1, 1, 32'h80FF12AB, 32'h80FF12AB};
    tbl[9]  = '{0, 2'd1, 1, 32'h50, 32'h0, 0, 2, 32'hFFFF80FF, 32'h80FF12AB};
    tbl[10] = '{1, 2'd1, 0, 32'h56, 32'hCAFE5678, 0, 3, 32'hFFFF80FF, 32'hDEAD5678};
    tbl[11] = '{0, 2'd1, 0, 32'h56, 32'h0, 0, 2, 32'h00005678, 32'hDEAD5678};

    @(negedge clk);
    tb_we = 1; tb_idx = 20; tb_wd = 32'h80FF1234; ref_mem[20] = 32'h80FF1234;
    @(negedge clk);
    tb_idx = 22; tb_wd = 32'h11223344; ref_mem[22] = 32'h11223344;
    @(negedge clk);
    tb_we = 0;
    chk("rst.outs", {busy, done, fault, memRead, memWrite}, 32'h0);
    chk("rst.loadData", loadData, 32'h0);
    chk("rst.memAddress", memAddress, 32'h0);
    chk("rst.memDataOut", memDataOut, 32'h0);
    reset = 0;

    for (int i = 0; i < 12; i++)
      apply($sformatf("tbl%0d", i), tbl[i].st, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].d,
            tbl[i].ef, tbl[i].el, tbl[i].eld, tbl[i].ew);

    @(negedge clk);
    req = 1; isStore = 1; size = 0; signedLoad = 0; addr = 32'h5A; storeData = 32'h99;
    @(negedge clk);
    req = 0;
    @(negedge clk);
    chk("rmwrst.inwrite", {31'b0, memWrite}, 32'h1);
    reset = 1;
    #1 chk("rmwrst.suppress", {31'b0, memWrite}, 32'h0);
    @(negedge clk);
    reset = 0;
    chk("rmwrst.outs", {busy, done, fault, memRead, memWrite}, 32'h0);
    chk("rmwrst.loadData", loadData, 32'h0);
    chk("rmwrst.memAddress", memAddress, 32'h0);
    chk("rmwrst.memDataOut", memDataOut, 32'h0);
    chk("rmwrst.word", mem[22], 32'h11223344);
    ref_ld = 0;
    apply("rmwrst.after", 0, 2'd2, 0, 32'h58, 32'h0, 0, 2, 32'h11223344, 32'h11223344);

    begin
      int r0;
      @(negedge clk);
      r0 = rd_cnt;
      req = 1; isStore = 0; size = 2; signedLoad = 0; addr = 32'h54;
      @(negedge clk);
      @(negedge clk);
      chk("hold.done", {31'b0, done}, 32'h1);
      @(negedge clk);
      chk("hold.idle", {31'b0, busy}, 32'h0);
      chk("hold.onerd", 32'(rd_cnt - r0), 32'h1);
      @(negedge clk);
      chk("hold.reaccept", {31'b0, busy}, 32'h1);
      req = 0;
      @(negedge clk);
      chk("hold.done2", {31'b0, done}, 32'h1);
      chk("hold.tword", 32'(rd_cnt - r0), 32'h2);
      chk("hold.loadData", loadData, ref_mem[21]);
      ref_ld = ref_mem[21];
    end

    for (int n = 0; n < 200; n++) begin
      logic st, s, f;
      logic [1:0] sz;
      logic [31:0] a, d, w, eld, ew;
      st = 1'($urandom % 2);
      sz = 2'($urandom % 4);
      s = 1'($urandom % 2);
      a = $urandom_range(0, 32'h1AF);
      if ($urandom % 2 == 1) a = sz == 1 ? a & ~32'h1 : sz == 2 ? a & ~32'h3 : a;
      d = $urandom;
      w = ref_mem[a[8:2]];
      f = model_fault(sz, a);
      eld = (f || st) ? ref_ld : model_load(w, sz, s, a);
      ew = (f || !st) ? w : model_store(w, sz, d, a);
      apply($sformatf("rnd%0d", n), st, sz, s, a, d, f,
            f ? 1 : (!st || sz == 2) ? 2 : 3, eld, ew);
    end

    chk("rd_wr_excl", {31'b0, both_seen}, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multicycle load/store sequencer between the datapath (ALU byte address, rt store data) and the word-addressed data memory. Converts byte/halfword/word requests into word-memory accesses: sub-word loads are lane-extracted and sign/zero-extended, and sub-word stores use a read-modify-write. Alignment and range faults are detected before any memory access. The control FSM issues one request and waits for `done`.

## Interface
- `MEM_WORDS`, default 101: number of valid memory words; word index ≥ `MEM_WORDS` faults.
- `clk`  in  1: single clock, all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `req`  in  1: request strobe; sampled only in IDLE.
- `isStore`  in  1: 1 = store, 0 = load.
- `size`  in  2: 00 byte, 01 halfword, 10 word, 11 illegal (faults).
- `signedLoad`  in  1: 1 = sign-extend sub-word load (lb/lh), 0 = zero-extend (lbu/lhu).
- `addr`  in  32: byte address.
- `storeData`  in  32: store value; byte/half taken from low bits.
- `loadData`  out  32: registered load result, held until next load completes.
- `busy`  out  1: high from the cycle after acceptance until `done`.
- `done`  out  1: one-cycle completion pulse.
- `fault`  out  1: valid with `done`; 1 = misaligned, out of range, or illegal size.
- `memAddress`  out  32: word index = `addr[31:2]` zero-extended, registered at acceptance.
- `memDataIn`  in  32: memory read data (combinational while `memRead` high).
- `memDataOut`  out  32: write data to memory.
- `memRead`, `memWrite`  out  1 each: memory strobes, decoded from state.

## Operation
- States: IDLE, LOAD, RMW_RD, RMW_WR, WR, DONE.
- IDLE + `req`: latch `isStore`, `size`, `signedLoad`, `addr[1:0]`, `storeData`, word index. Fault check: half with `addr[0]`=1, word with `addr[1:0]`≠0, size 11, or index ≥ `MEM_WORDS` → DONE with fault set, no memory strobe. Otherwise: load→LOAD, word store→WR, sub-word store→RMW_RD.
- Lanes big-endian (MIPS): byte offset 0 = bits 31:24, offset 3 = bits 7:0; half offset 0 = bits 31:16.
- LOAD: `memRead`=1; extract lane from `memDataIn`, extend, register into `loadData`; → DONE.
- RMW_RD: `memRead`=1; register `memDataIn` into merge buffer; → RMW_WR.
- RMW_WR: `memWrite`=1; `memDataOut` = buffer with addressed lane replaced by `storeData[7:0]`/`[15:0]`; → DONE.
- WR: `memWrite`=1, `memDataOut` = `storeData`; → DONE.
- DONE: `done`=1, `fault` as latched; → IDLE. `req` in DONE ignored (earliest next acceptance is the following IDLE cycle).
- `req` while busy is ignored, not queued.
- Faulted loads leave `loadData` unchanged.

## Timing
- Latency `req` to `done`: load 2 cycles, word store 2, sub-word store 3, fault 1 (done in cycle after acceptance).
- Back-to-back throughput: one request per latency+1 cycles.
- `memWrite` = (state is WR or RMW_WR) AND NOT `reset`: reset asserted during a write cycle suppresses that write.
- Reset (any state, any cycle): next state IDLE; `loadData`, `memAddress`, `memDataOut`, merge buffer = 0; `busy`, `done`, `fault`, `memRead`, `memWrite` = 0.
- `memRead` is never high in the same cycle as `memWrite`.

## Structure
- Package `lsu_pkg`: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enumeration, lane-offset constants.
- Sub-module `lsu_lane_align` (combinational): extract+extend for loads and lane merge for stores; size, offset, and signedness are inputs. FSM and registers live in `load_store_unit`.

## Test plan
- Word 20 = 0x80FF1234; lb addr 0x50 signed → `loadData` 0xFFFFFF80, `done` 2 cycles after `req`; lbu addr 0x51 → 0x000000FF.
- lh addr 0x52 signed, same word → 0x00001234; lh addr 0x51 → fault=1, done after 1 cycle, no `memRead`, `loadData` unchanged.
- sb 0xAB to addr 0x53 over 0x80FF1234 → RMW_RD then RMW_WR, memory word 0x80FF12AB, `done` at cycle 3.
- sw 0xDEADBEEF addr 0x54 → single `memWrite` cycle, word 21 = 0xDEADBEEF; sw addr 0x194 (index 101) → fault, no write.
- Assert `reset` during RMW_WR → no write reaches memory, all outputs 0 next cycle, next `req` accepted normally.
- `req` held high during a busy load → exactly one access; second request accepted only after IDLE.
